// File: rtl/vec_seq_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vec_seq_ctrl_pkg : opcodes, FP lane-unit encodings, sequencer states, lane slice
// Revision : 1.0
// ============================================================================
package vec_seq_ctrl_pkg;

  localparam logic [3:0] OP_VADD = 4'b0000;
  localparam logic [3:0] OP_VDOT = 4'b0001;
  localparam logic [3:0] OP_SMUL = 4'b0010;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  localparam logic FP_ADD = 1'b0;
  localparam logic FP_MUL = 1'b1;

  localparam int VEC_LANES = 16;
  localparam int VEC_LW    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FIN   = 2'd2
  } state_t;

  function automatic logic [VEC_LW-1:0] LANE(input logic [VEC_LANES*VEC_LW-1:0] v,
                                             input int unsigned i);
    return v[i*VEC_LW +: VEC_LW];
  endfunction

endpackage
`default_nettype wire

// File: rtl/vec_seq_ctrl_lane_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vec_lane_counter : lane index plus VDOT mul/add phase, with last-step flag
// Revision : 1.0
// ============================================================================
module vec_lane_counter #(
  parameter int LANES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic                       inc_i,
  input  logic                       dot_i,
  output logic [$clog2(LANES)-1:0]   lane_o,
  output logic                       phase_o,
  output logic                       last_o
);
  localparam int LIW = $clog2(LANES);
  localparam logic [LIW-1:0] C_LAST = LIW'(LANES - 1);

  logic [LIW-1:0] lane_q, lane_d;
  logic           phase_q, phase_d;

  // VDOT takes two steps (mul then add) per lane; other ops advance every step.
  always_comb begin
    lane_d  = lane_q;
    phase_d = phase_q;
    if (clear_i) begin
      lane_d  = '0;
      phase_d = 1'b0;
    end else if (inc_i) begin
      if (dot_i && !phase_q) begin
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        lane_d  = lane_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      phase_q <= phase_d;
    end
  end

  assign lane_o  = lane_q;
  assign phase_o = phase_q;
  assign last_o  = (lane_q == C_LAST) && (!dot_i || phase_q);

endmodule
`default_nettype wire

// File: rtl/vec_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vec_seq_ctrl : multi-cycle VADD/VDOT/SMUL sequencer over a shared FP lane unit
// Revision : 1.0
// ============================================================================
module vec_seq_ctrl
  import vec_seq_ctrl_pkg::*;
#(
  parameter int LANES    = 16,
  parameter int LW       = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0]          opcode,
  input  logic [LANES*LW-1:0] op_1,
  input  logic [LANES*LW-1:0] op_2,
  output logic                busy,
  output logic                done,
  output logic [LANES*LW-1:0] result,
  output logic                err,
  output logic                fp_req,
  output logic                fp_op,
  output logic [LW-1:0]       fp_a,
  output logic [LW-1:0]       fp_b,
  input  logic                fp_ack,
  input  logic [LW-1:0]       fp_res
);
  localparam int VW  = LANES * LW;
  localparam int LIW = $clog2(LANES);
  localparam int WW  = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] C_WAIT_LAST = WW'(MAX_WAIT - 1);

  state_t        state_q;
  logic [3:0]    opc_q;
  logic [VW-1:0] a_q, b_q, res_q, result_q;
  logic [LW-1:0] acc_q, fp_a_q, fp_b_q;
  logic [WW-1:0] wait_q;
  logic          busy_q, done_q, err_q, fp_req_q, fp_op_q;

  logic [LIW-1:0] lane, lane_nxt;
  logic           phase, last, is_dot, legal, accept, acked;
  logic [VW-1:0]  res_upd;
  logic           nxt_op;
  logic [LW-1:0]  nxt_a, nxt_b;

  assign is_dot   = (opc_q == OP_VDOT);
  assign legal    = (opcode == OP_VADD) || (opcode == OP_VDOT) || (opcode == OP_SMUL);
  assign accept   = start && (state_q == ST_IDLE);
  assign acked    = (state_q == ST_ISSUE) && fp_ack;
  assign lane_nxt = lane + 1'b1;

  vec_lane_counter #(
    .LANES(LANES)
  ) u_lane_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear_i(accept),
    .inc_i  (acked),
    .dot_i  (is_dot),
    .lane_o (lane),
    .phase_o(phase),
    .last_o (last)
  );

  // Operands for the request that follows the one being acknowledged now.
  always_comb begin
    res_upd                 = res_q;
    res_upd[lane*LW +: LW]  = fp_res;
    nxt_op                  = FP_ADD;
    nxt_a                   = a_q[lane_nxt*LW +: LW];
    nxt_b                   = b_q[lane_nxt*LW +: LW];
    case (opc_q)
      OP_SMUL: begin
        nxt_op = FP_MUL;
        nxt_a  = a_q[LW-1:0];
      end
      OP_VDOT: begin
        if (!phase) begin
          nxt_a = acc_q;
          nxt_b = fp_res;
        end else begin
          nxt_op = FP_MUL;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      opc_q    <= OP_NOP;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      result_q <= '0;
      acc_q    <= '0;
      wait_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      fp_req_q <= 1'b0;
      fp_op_q  <= 1'b0;
      fp_a_q   <= '0;
      fp_b_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            opc_q  <= opcode;
            a_q    <= op_1;
            b_q    <= op_2;
            acc_q  <= '0;
            res_q  <= '0;
            wait_q <= '0;
            if (legal) begin
              state_q  <= ST_ISSUE;
              busy_q   <= 1'b1;
              err_q    <= 1'b0;
              fp_req_q <= 1'b1;
              fp_op_q  <= (opcode == OP_VADD) ? FP_ADD : FP_MUL;
              fp_a_q   <= op_1[LW-1:0];
              fp_b_q   <= op_2[LW-1:0];
            end else begin
              state_q  <= ST_FIN;
              done_q   <= 1'b1;
              err_q    <= 1'b1;
              result_q <= '0;
            end
          end
        end
        ST_ISSUE: begin
          if (fp_ack) begin
            wait_q <= '0;
            if (is_dot) begin
              if (phase) acc_q <= fp_res;
            end else begin
              res_q <= res_upd;
            end
            if (last) begin
              state_q  <= ST_FIN;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              fp_req_q <= 1'b0;
              result_q <= is_dot ? {{(VW-LW){1'b0}}, fp_res} : res_upd;
            end else begin
              fp_op_q <= nxt_op;
              fp_a_q  <= nxt_a;
              fp_b_q  <= nxt_b;
            end
          end else if (wait_q == C_WAIT_LAST) begin
            // Unanswered request: give up, keeping only lanes already finished.
            state_q  <= ST_FIN;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= 1'b1;
            fp_req_q <= 1'b0;
            result_q <= res_q;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
  assign fp_req = fp_req_q;
  assign fp_op  = fp_op_q;
  assign fp_a   = fp_a_q;
  assign fp_b   = fp_b_q;

endmodule
`default_nettype wire

// File: tb/tb_vec_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_vec_seq_ctrl : scoreboard bench with a behavioural half-precision FP unit
// Revision : 1.0
// ============================================================================
module tb_vec_seq_ctrl;
  import vec_seq_ctrl_pkg::*;

  localparam int LANES = 16;
  localparam int LW    = 16;
  localparam int VW    = LANES * LW;
  localparam int MAXW  = 8;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0]    opcode = 4'b0;
  logic [VW-1:0] op_1 = '0, op_2 = '0;
  logic          busy, done, err, fp_req, fp_op;
  logic [VW-1:0] result;
  logic [LW-1:0] fp_a, fp_b;
  logic          fp_ack = 1'b0;
  logic [LW-1:0] fp_res = '0;

  vec_seq_ctrl #(.LANES(LANES), .LW(LW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .op_1(op_1), .op_2(op_2),
    .busy(busy), .done(done), .result(result), .err(err),
    .fp_req(fp_req), .fp_op(fp_op), .fp_a(fp_a), .fp_b(fp_b),
    .fp_ack(fp_ack), .fp_res(fp_res)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [VW-1:0] res;
    logic          err;
    int            t0;
    int            base_lat;
    int            nreq;
    int            nmul;
    bit            tmo;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int            stall_max = 0, stall_left = 0;
  bit            ack_en = 1'b1, fresh = 1'b1;
  int            stall_total = 0, req_cnt = 0, mul_cnt = 0, req_hi = 0;
  logic          hold_op;
  logic [LW-1:0] hold_a, hold_b;
  logic [VW-1:0] va, vb;
  logic [3:0]    ropc;

  task automatic check_v(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic check_i(input string nm, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic real h2r(input logic [15:0] h);
    real v;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) begin
      v = real'(h[9:0]) / 1024.0;
      e = 1;
    end else begin
      v = 1.0 + real'(h[9:0]) / 1024.0;
    end
    for (int k = 15; k < e; k++) v = v * 2.0;
    for (int k = e; k < 15; k++) v = v / 2.0;
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real x);
    real  v;
    int   e;
    logic s;
    if (x == 0.0) return 16'h0000;
    s = (x < 0.0);
    v = s ? -x : x;
    e = 15;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    return {s, 5'(e), 10'($rtoi((v - 1.0) * 1024.0 + 0.5))};
  endfunction

  function automatic logic [VW-1:0] splat(input logic [15:0] h);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*LW +: LW] = h;
    return v;
  endfunction

  // Small signed integers keep every sum/product exactly representable.
  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*LW +: LW] = r2h(real'($urandom_range(0, 14)) - 7.0);
    return v;
  endfunction

  // Reference: vector semantics straight from the opcode definitions.
  function automatic exp_t model(input logic [3:0] opc, input logic [VW-1:0] a,
                                 input logic [VW-1:0] b, input bit aen);
    exp_t e;
    real  acc;
    e.res = '0; e.err = 1'b0; e.t0 = 0; e.nreq = 0; e.nmul = 0; e.tmo = 1'b0;
    e.base_lat = 1;
    if (opc != OP_VADD && opc != OP_VDOT && opc != OP_SMUL) begin
      e.err = 1'b1;
    end else if (!aen) begin
      e.err = 1'b1; e.tmo = 1'b1; e.base_lat = MAXW + 1;
    end else if (opc == OP_VADD) begin
      for (int i = 0; i < LANES; i++)
        e.res[i*LW +: LW] = r2h(h2r(LANE(a, i)) + h2r(LANE(b, i)));
      e.base_lat = LANES + 1; e.nreq = LANES;
    end else if (opc == OP_SMUL) begin
      for (int i = 0; i < LANES; i++)
        e.res[i*LW +: LW] = r2h(h2r(LANE(a, 0)) * h2r(LANE(b, i)));
      e.base_lat = LANES + 1; e.nreq = LANES; e.nmul = LANES;
    end else begin
      acc = 0.0;
      for (int i = 0; i < LANES; i++) acc = acc + h2r(LANE(a, i)) * h2r(LANE(b, i));
      e.res[LW-1:0] = r2h(acc);
      e.base_lat = 2 * LANES + 1; e.nreq = 2 * LANES; e.nmul = LANES;
    end
    return e;
  endfunction

  // Behavioural FP lane unit with random ack stalls.
  always @(negedge clk) begin
    if (fp_req) req_hi++;
    if (fp_req && ack_en && !rst) begin
      if (fresh) begin
        stall_left = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
        hold_op = fp_op; hold_a = fp_a; hold_b = fp_b;
        fresh = 1'b0;
      end else begin
        check_v("stall_operands_stable", VW'({fp_op, fp_a, fp_b}), VW'({hold_op, hold_a, hold_b}));
      end
      if (stall_left > 0) begin
        fp_ack = 1'b0;
        stall_left--;
        stall_total++;
      end else begin
        fp_ack = 1'b1;
        fp_res = fp_op ? r2h(h2r(fp_a) * h2r(fp_b)) : r2h(h2r(fp_a) + h2r(fp_b));
        fresh  = 1'b1;
        req_cnt++;
        if (fp_op) mul_cnt++;
      end
    end else begin
      fp_ack = 1'b0;
      fresh  = 1'b1;
    end
  end

  // Monitor: pops the oldest expectation whenever done is presented.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation");
      end else begin
        mon_e = sb.pop_front();
        check_v("result", result, mon_e.res);
        check_i("err", int'(err), int'(mon_e.err));
        check_i("busy_at_done", int'(busy), 0);
        check_i("latency", cyc - mon_e.t0, mon_e.base_lat + (mon_e.tmo ? 0 : stall_total));
        check_i("fp_acks", req_cnt, mon_e.nreq);
        check_i("fp_mul_reqs", mul_cnt, mon_e.nmul);
        check_i("fp_req_cycles", req_hi, mon_e.tmo ? MAXW : mon_e.nreq + stall_total);
      end
    end
  end

  task automatic run_op(input logic [3:0] opc, input logic [VW-1:0] a, input logic [VW-1:0] b,
                        input int smax, input bit aen, input bit poke);
    exp_t e;
    bit   got;
    e = model(opc, a, b, aen);
    @(posedge clk); #1;
    stall_max = smax; ack_en = aen;
    stall_total = 0; req_cnt = 0; mul_cnt = 0; req_hi = 0;
    e.t0 = cyc;
    sb.push_back(e);
    opcode = opc; op_1 = a; op_2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; opcode = 4'b0110; op_1 = ~a; op_2 = ~b;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      start = poke && (k == 4);
      if (done) got = 1'b1;
    end
    if (got && poke) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done in 200 cycles expected done");
      if (sb.size() > 0) void'(sb.pop_front());
    end
    ack_en = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_i("reset_busy", int'(busy), 0);
    check_i("reset_done", int'(done), 0);
    check_i("reset_err", int'(err), 0);
    check_i("reset_fp_req", int'(fp_req), 0);
    check_v("reset_result", result, '0);
    check_v("reset_fp_ops", VW'({fp_op, fp_a, fp_b}), '0);
    rst = 1'b0;

    run_op(OP_VADD, splat(16'h3C00), splat(16'h3C00), 0, 1'b1, 1'b0);
    run_op(OP_VDOT, splat(16'h3C00), splat(16'h4000), 0, 1'b1, 1'b0);
    va = rand_vec();
    va[15:0] = 16'h4000;
    run_op(OP_SMUL, va, splat(16'h4200), 2, 1'b1, 1'b0);
    run_op(4'b0110, rand_vec(), rand_vec(), 0, 1'b1, 1'b0);
    run_op(OP_VADD, rand_vec(), rand_vec(), 1, 1'b1, 1'b1);
    run_op(OP_VDOT, rand_vec(), rand_vec(), 0, 1'b0, 1'b0);
    run_op(OP_SMUL, rand_vec(), rand_vec(), 0, 1'b0, 1'b0);

    // Reset in the middle of a VADD.
    @(posedge clk); #1;
    stall_max = 0; ack_en = 1'b1; req_cnt = 0;
    opcode = OP_VADD; op_1 = rand_vec(); op_2 = rand_vec(); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 50 && req_cnt < 5; k++) @(negedge clk);
    check_i("busy_before_rst", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check_i("rst_fp_req", int'(fp_req), 0);
    check_i("rst_busy", int'(busy), 0);
    check_i("rst_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op(OP_VADD, rand_vec(), rand_vec(), 0, 1'b1, 1'b0);

    for (int n = 0; n < 6; n++) begin
      case ($urandom_range(0, 2))
        0:       ropc = OP_VADD;
        1:       ropc = OP_VDOT;
        default: ropc = OP_SMUL;
      endcase
      va = rand_vec();
      vb = rand_vec();
      run_op(ropc, va, vb, int'($urandom_range(0, 2)), 1'b1, n[0]);
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
